uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 3: number of byte-stream requesters (0 = BLE setup, 1 = data path, 2 = status reporter).
REQ-002 Parameter MAX_LEN, default 64: maximum bytes in one locked burst.
REQ-003 Parameter IDLE_TIMEOUT, default 1000: clock cycles a locked requester may go without a transfer.
REQ-004 clk  input  1  clock; all logic is rising-edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 req_valid  input  NUM_REQ  per-requester byte-valid.
REQ-007 req_byte  input  8*NUM_REQ  per-requester byte; requester i occupies bits [8i+7:8i].
REQ-008 req_ready  output  NUM_REQ  per-requester byte accepted in this cycle when high together with req_valid.
REQ-009 tx_full  input  1  UART TX FIFO full flag.
REQ-010 tx_wr_en  output  1  TX FIFO write strobe.
REQ-011 tx_data  output  8  TX FIFO write byte.
REQ-012 grant  output  NUM_REQ  one-hot owner of the TX path; all-zero when unlocked.
REQ-013 busy  output  1  high while a requester holds the lock.
REQ-014 overflow_err  output  1  one-cycle pulse: burst hit MAX_LEN without a terminator.
REQ-015 timeout_err  output  1  one-cycle pulse: lock dropped on idle timeout.

Function
REQ-016 FSM states SHALL be IDLE and LOCKED, and only these.
REQ-017 IDLE: when any req_valid is high, the arbiter SHALL register a one-hot grant round-robin, searching from index (last_owner+1) mod NUM_REQ, and go to LOCKED on the next edge. No byte is accepted in IDLE.
REQ-018 LOCKED: req_ready[g] = !tx_full for the granted index g; all other req_ready bits SHALL be 0.
REQ-019 Transfer: tx_wr_en = req_valid[g] & req_ready[g]; tx_data = req_byte of g. Both combinational, zero latency. tx_data SHALL be 0 when tx_wr_en is low.
REQ-020 tx_wr_en SHALL never be high while tx_full is high.
REQ-021 The terminator is an accepted 0x0A whose preceding accepted byte in the same burst was 0x0D. On its transfer the FSM SHALL return to IDLE on the next edge and update last_owner to g.
REQ-022 A 7-bit burst counter SHALL count accepted bytes and clear on every lock.
REQ-023 If the MAX_LEN-th accepted byte is not a terminator, the FSM SHALL release the lock as in REQ-021 and pulse overflow_err in the following cycle.
REQ-024 An idle counter SHALL clear on each transfer and increment each LOCKED cycle without a transfer. Cycles with tx_full high SHALL NOT count.
REQ-025 When the idle counter reaches IDLE_TIMEOUT, the FSM SHALL release (last_owner = g) and pulse timeout_err.
REQ-026 After any release, at least one IDLE cycle SHALL occur before a new grant (one-cycle re-arbitration gap).
REQ-027 Terminator and MAX_LEN on the same byte: treat as a terminator; overflow_err SHALL NOT pulse.
REQ-028 The 0x0D tracking flag SHALL clear on any non-0x0D accepted byte and on release.
REQ-029 busy SHALL equal (state == LOCKED). grant SHALL be one-hot in LOCKED and zero in IDLE.

Reset
REQ-030 On rst_n low, asynchronously: state = IDLE; grant, busy, req_ready, tx_wr_en, tx_data, overflow_err and timeout_err = 0; counters and 0x0D flag cleared; last_owner = NUM_REQ-1, so requester 0 has first priority.
REQ-031 Reset mid-burst SHALL abandon the burst, with no further tx_wr_en after reset asserts.

Structure
REQ-032 Shared package uart_arb_pkg SHALL hold the state enum, the CR (0x0D) and LF (0x0A) constants, and the NUM_REQ, MAX_LEN and IDLE_TIMEOUT defaults.
REQ-033 Round-robin selection SHALL be a sub-module rr_arbiter (inputs: request vector and last_owner; output: one-hot select).

Verification
REQ-034 Req0 only sends "AT\r\n" with tx_full=0 -> grant=001 one cycle after valid; 4 tx_wr_en pulses with tx_data 41,54,0D,0A; busy falls one edge after 0A.
REQ-035 All three requesters valid from reset, each sending "X\r\n" -> grant sequence 001, 010, 100, each separated by one IDLE cycle.
REQ-036 Req1 locked, tx_full=1 for 20 cycles mid-burst -> req_ready[1]=0, no tx_wr_en, no timeout_err; the burst resumes intact.
REQ-037 Req2 locked, valid dropped for 1000 cycles -> timeout_err pulses once, grant=000, and req0 is granted next if valid.
REQ-038 Req0 streams 64 bytes of 0x41 -> 64 writes, release, overflow_err pulse, 65th byte not accepted in that cycle.
REQ-039 rst_n asserted after 2 bytes of a burst -> all outputs 0 immediately; after release, req0 wins arbitration.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// Shared definitions for the UART TX arbiter slice.
//   - arb_state_e        : arbiter FSM states (IDLE / LOCKED)
//   - CR, LF             : byte values forming the burst terminator (CR then LF)
//   - DEF_*              : default parameter values for the arbiter
//   - BURST_W            : width of the per-burst accepted-byte counter
//   - idx_w()            : index width for a requester count (never below 1)
package uart_arb_pkg;

  localparam int DEF_NUM_REQ      = 3;
  localparam int DEF_MAX_LEN      = 64;
  localparam int DEF_IDLE_TIMEOUT = 1000;

  localparam int BURST_W = 7;

  localparam logic [7:0] CR = 8'h0D;
  localparam logic [7:0] LF = 8'h0A;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_e;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin selector.
//   req        : request vector, one bit per requester
//   last_owner : index of the requester that held the lock most recently
//   sel        : one-hot winner, all-zero when no request is pending
// The search starts one past last_owner and wraps, so the previous owner
// has the lowest priority on the next round.
module rr_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int IDX_W   = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_owner,
  output logic [NUM_REQ-1:0] sel
);

  int   idx;
  logic found;

  always_comb begin
    sel   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_owner) + k) % NUM_REQ;
      if (!found && req[idx]) begin
        sel[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Arbitrates several byte-stream requesters onto one UART TX FIFO write port.
// A requester is locked onto the TX path for a whole burst; the burst ends on
// a CR LF pair, on MAX_LEN accepted bytes (overflow_err) or on IDLE_TIMEOUT
// counted idle cycles (timeout_err).
//
// Handshake: a byte moves on a requester channel in every cycle where
// req_valid[i] and req_ready[i] are both high at the rising edge of clk. The
// requester must hold req_byte stable while req_valid is high and ready low;
// ready never depends on anything except lock ownership and tx_full.
//
// Ports:
//   clk, rst_n    : clock (rising edge), asynchronous active-low reset
//   req_valid     : per-requester byte valid
//   req_byte      : per-requester byte, requester i in bits [8i+7:8i]
//   req_ready     : per-requester ready (only the lock owner, only if !tx_full)
//   tx_full       : TX FIFO full flag
//   tx_wr_en      : TX FIFO write strobe (combinational from the handshake)
//   tx_data       : TX FIFO write byte, zero whenever tx_wr_en is low
//   grant         : one-hot lock owner, zero when unlocked
//   busy          : high while a requester holds the lock
//   overflow_err  : one-cycle pulse after a burst hit MAX_LEN unterminated
//   timeout_err   : one-cycle pulse after a lock was dropped for idleness
//   dbg_state     : current FSM state
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ      = DEF_NUM_REQ,
  parameter int MAX_LEN      = DEF_MAX_LEN,
  parameter int IDLE_TIMEOUT = DEF_IDLE_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_byte,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic                 tx_full,
  output logic                 tx_wr_en,
  output logic [7:0]           tx_data,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 busy,
  output logic                 overflow_err,
  output logic                 timeout_err,
  output arb_state_e           dbg_state
);

  localparam int IDX_W  = idx_w(NUM_REQ);
  localparam int IDLE_W = $clog2(IDLE_TIMEOUT + 1);

  // Compare against the value before increment so the check happens on the
  // byte / idle cycle that completes the count.
  localparam logic [BURST_W-1:0] LAST_BYTE = BURST_W'(MAX_LEN - 1);
  localparam logic [IDLE_W-1:0]  IDLE_LAST = IDLE_W'(IDLE_TIMEOUT - 1);

  arb_state_e           state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]     last_owner_q, last_owner_d;
  logic [BURST_W-1:0]   burst_cnt_q, burst_cnt_d;
  logic [IDLE_W-1:0]    idle_cnt_q, idle_cnt_d;
  logic                 cr_seen_q, cr_seen_d;
  logic                 ovf_q, ovf_d;
  logic                 to_q, to_d;

  logic [NUM_REQ-1:0]   rr_sel;
  logic [IDX_W-1:0]     owner_idx;
  logic [7:0]           owner_byte;
  logic                 fire;
  logic                 is_term;
  logic                 at_max;
  logic                 release_lock;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req        (req_valid),
    .last_owner (last_owner_q),
    .sel        (rr_sel)
  );

  // Owner index and its byte lane, decoded from the one-hot grant.
  always_comb begin
    owner_idx  = '0;
    owner_byte = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) begin
        owner_idx  = IDX_W'(i);
        owner_byte = req_byte[8*i +: 8];
      end
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_owner_d = last_owner_q;
    burst_cnt_d  = burst_cnt_q;
    idle_cnt_d   = idle_cnt_q;
    cr_seen_d    = cr_seen_q;
    ovf_d        = 1'b0;
    to_d         = 1'b0;
    req_ready    = '0;
    tx_wr_en     = 1'b0;
    tx_data      = '0;
    fire         = 1'b0;
    is_term      = 1'b0;
    at_max       = 1'b0;
    release_lock = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Arbitrate only; no byte moves in IDLE.
        if (|req_valid) begin
          state_d     = ST_LOCKED;
          grant_d     = rr_sel;
          burst_cnt_d = '0;
          idle_cnt_d  = '0;
          cr_seen_d   = 1'b0;
        end
      end

      ST_LOCKED: begin
        req_ready = tx_full ? '0 : grant_q;
        fire      = |(req_valid & req_ready);
        tx_wr_en  = fire;
        tx_data   = fire ? owner_byte : 8'h00;

        if (fire) begin
          is_term     = (owner_byte == LF) && cr_seen_q;
          at_max      = (burst_cnt_q == LAST_BYTE);
          burst_cnt_d = burst_cnt_q + 1'b1;
          idle_cnt_d  = '0;
          cr_seen_d   = (owner_byte == CR);
          // A terminator landing exactly on the length limit is a clean end.
          release_lock = is_term || at_max;
          ovf_d        = at_max && !is_term;
        end else if (!tx_full) begin
          // Back-pressure from the FIFO is not the requester's fault, so
          // only unstalled empty cycles count toward the timeout.
          if (idle_cnt_q == IDLE_LAST) begin
            release_lock = 1'b1;
            to_d         = 1'b1;
          end else begin
            idle_cnt_d = idle_cnt_q + 1'b1;
          end
        end

        if (release_lock) begin
          state_d      = ST_IDLE;
          grant_d      = '0;
          last_owner_d = owner_idx;
          cr_seen_d    = 1'b0;
        end
      end

      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      last_owner_q <= IDX_W'(NUM_REQ - 1);
      burst_cnt_q  <= '0;
      idle_cnt_q   <= '0;
      cr_seen_q    <= 1'b0;
      ovf_q        <= 1'b0;
      to_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_owner_q <= last_owner_d;
      burst_cnt_q  <= burst_cnt_d;
      idle_cnt_q   <= idle_cnt_d;
      cr_seen_q    <= cr_seen_d;
      ovf_q        <= ovf_d;
      to_q         <= to_d;
    end
  end

  assign grant        = grant_q;
  assign busy         = (state_q == ST_LOCKED);
  assign overflow_err = ovf_q;
  assign timeout_err  = to_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: a cycle model built on plain
// integers and queues, a byte scoreboard fed by the directed tests, and
// literal expectations for grant order, latencies and error pulses.
module tb_uart_tx_arbiter;
  import uart_arb_pkg::*;

  localparam int N    = 3;
  localparam int MAXL = 64;
  localparam int TMO  = 1000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_byte;
  logic [N-1:0]   req_ready;
  logic           tx_full;
  logic           tx_wr_en;
  logic [7:0]     tx_data;
  logic [N-1:0]   grant;
  logic           busy;
  logic           overflow_err;
  logic           timeout_err;
  arb_state_e     dbg_state;

  uart_tx_arbiter #(.NUM_REQ(N), .MAX_LEN(MAXL), .IDLE_TIMEOUT(TMO)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_byte     (req_byte),
    .req_ready    (req_ready),
    .tx_full      (tx_full),
    .tx_wr_en     (tx_wr_en),
    .tx_data      (tx_data),
    .grant        (grant),
    .busy         (busy),
    .overflow_err (overflow_err),
    .timeout_err  (timeout_err),
    .dbg_state    (dbg_state)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- stimulus sources ----------------
  logic [7:0] src0_q[$];
  logic [7:0] src1_q[$];
  logic [7:0] src2_q[$];
  logic [7:0] exp_q[$];
  logic       full_cfg = 1'b0;
  logic [N-1:0] acc = '0;

  task automatic push(input int r, input logic [7:0] b, input bit expect_it);
    case (r)
      0:       src0_q.push_back(b);
      1:       src1_q.push_back(b);
      default: src2_q.push_back(b);
    endcase
    if (expect_it) exp_q.push_back(b);
  endtask

  // Driver: consume accepted bytes just after the edge, present the next ones.
  initial begin
    req_valid = '0;
    req_byte  = '0;
    tx_full   = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (acc[0] && src0_q.size() > 0) void'(src0_q.pop_front());
      if (acc[1] && src1_q.size() > 0) void'(src1_q.pop_front());
      if (acc[2] && src2_q.size() > 0) void'(src2_q.pop_front());
      req_valid[0]    = (src0_q.size() > 0);
      req_valid[1]    = (src1_q.size() > 0);
      req_valid[2]    = (src2_q.size() > 0);
      req_byte[7:0]   = (src0_q.size() > 0) ? src0_q[0] : 8'h00;
      req_byte[15:8]  = (src1_q.size() > 0) ? src1_q[0] : 8'h00;
      req_byte[23:16] = (src2_q.size() > 0) ? src2_q[0] : 8'h00;
      tx_full         = full_cfg;
    end
  end

  // ---------------- model state and logs ----------------
  int m_owner = -1;
  int m_last  = N - 1;
  int m_cnt   = 0;
  int m_idle  = 0;
  bit m_cr    = 0;
  bit m_ovf_p = 0;
  bit m_to_p  = 0;

  int cyc = 0;
  int wr_total = 0;
  logic [N-1:0] grant_log[$];
  int gap_log[$];
  int burst_log[$];
  int burst_wr, zero_run;
  int valid_cyc, grant_cyc, fall_cyc, first_wr_cyc, last_wr_cyc, to_cyc, ov_cyc;
  int to_cnt, ov_cnt;
  logic [N-1:0] prev_grant = '0;

  task automatic clear_logs();
    grant_log.delete();
    gap_log.delete();
    burst_log.delete();
    burst_wr = 0; zero_run = 0;
    valid_cyc = -1; grant_cyc = -1; fall_cyc = -1;
    first_wr_cyc = -1; last_wr_cyc = -1; to_cyc = -1; ov_cyc = -1;
    to_cnt = 0; ov_cnt = 0;
  endtask

  // ---------------- compare process / scoreboard ----------------
  logic [N-1:0] e_grant, e_ready;
  logic         e_wr;
  logic [7:0]   e_data, cur, sb_exp;
  arb_state_e   e_state;
  int           c;

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        chk("rst_grant", grant, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", req_ready, 0);
        chk("rst_wr", tx_wr_en, 0);
        chk("rst_data", tx_data, 0);
        chk("rst_ovf", overflow_err, 0);
        chk("rst_to", timeout_err, 0);
        m_owner = -1; m_last = N - 1; m_cnt = 0; m_idle = 0;
        m_cr = 0; m_ovf_p = 0; m_to_p = 0;
      end else begin
        e_grant = '0; e_ready = '0; e_wr = 1'b0; e_data = 8'h00; cur = 8'h00;
        if (m_owner >= 0) begin
          e_grant[m_owner] = 1'b1;
          if (!tx_full) e_ready[m_owner] = 1'b1;
          cur  = req_byte[8*m_owner +: 8];
          e_wr = req_valid[m_owner] && !tx_full;
          if (e_wr) e_data = cur;
        end
        e_state = (m_owner >= 0) ? ST_LOCKED : ST_IDLE;
        chk("grant", grant, e_grant);
        chk("busy", busy, (m_owner >= 0));
        chk("state", dbg_state, e_state);
        chk("req_ready", req_ready, e_ready);
        chk("tx_wr_en", tx_wr_en, e_wr);
        chk("tx_data", tx_data, e_data);
        chk("overflow_err", overflow_err, m_ovf_p);
        chk("timeout_err", timeout_err, m_to_p);

        if (tx_wr_en) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_extra: write of %0h with nothing expected", tx_data);
          end else begin
            sb_exp = exp_q.pop_front();
            chk("sb_data", tx_data, sb_exp);
          end
        end

        // Advance the model to the state after the coming edge.
        m_ovf_p = 0; m_to_p = 0;
        if (m_owner < 0) begin
          if (req_valid != '0) begin
            for (int k = 1; k <= N; k++) begin
              c = (m_last + k) % N;
              if (req_valid[c]) begin
                m_owner = c;
                break;
              end
            end
            m_cnt = 0; m_idle = 0; m_cr = 0;
          end
        end else if (e_wr) begin
          m_cnt++;
          m_idle = 0;
          if (cur == 8'h0A && m_cr) begin
            m_last = m_owner; m_owner = -1; m_cr = 0;
          end else if (m_cnt == MAXL) begin
            m_last = m_owner; m_owner = -1; m_cr = 0; m_ovf_p = 1;
          end else begin
            m_cr = (cur == 8'h0D);
          end
        end else if (!tx_full) begin
          m_idle++;
          if (m_idle == TMO) begin
            m_last = m_owner; m_owner = -1; m_cr = 0; m_to_p = 1;
          end
        end

        // Event logs used by the directed literal checks.
        if (req_valid != '0 && valid_cyc < 0) valid_cyc = cyc;
        if (grant != '0 && prev_grant == '0) begin
          grant_log.push_back(grant);
          gap_log.push_back(zero_run);
          if (grant_cyc < 0) grant_cyc = cyc;
          burst_wr = 0;
        end
        if (grant == '0 && prev_grant != '0) begin
          burst_log.push_back(burst_wr);
          if (fall_cyc < 0) fall_cyc = cyc;
        end
        if (grant == '0) zero_run++; else zero_run = 0;
        if (tx_wr_en) begin
          wr_total++;
          burst_wr++;
          last_wr_cyc = cyc;
          if (first_wr_cyc < 0) first_wr_cyc = cyc;
        end
        if (timeout_err) begin to_cnt++; if (to_cyc < 0) to_cyc = cyc; end
        if (overflow_err) begin ov_cnt++; if (ov_cyc < 0) ov_cyc = cyc; end
      end
      acc = req_valid & req_ready;
      prev_grant = grant;
    end
  end

  // ---------------- helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #2;
  endtask

  task automatic wait_drain(input int budget, input string name);
    bit ok;
    ok = 0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      #2;
      if (src0_q.size() == 0 && src1_q.size() == 0 && src2_q.size() == 0 && m_owner < 0) begin
        ok = 1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s_drain: still active after %0d cycles", name, budget);
    end
    tick(2);
    chk({name, "_exp_empty"}, exp_q.size(), 0);
  endtask

  task automatic wait_src_empty(input int r, input int budget, input string name);
    bit ok;
    ok = 0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      #2;
      if ((r == 0 && src0_q.size() == 0) || (r == 1 && src1_q.size() == 0) ||
          (r == 2 && src2_q.size() == 0)) begin
        ok = 1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s_src_empty: requester %0d not drained in %0d cycles", name, r, budget);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(1);
  endtask

  function automatic logic [N-1:0] glog(input int i);
    return (grant_log.size() > i) ? grant_log[i] : '0;
  endfunction

  function automatic int ilog_b(input int i);
    return (burst_log.size() > i) ? burst_log[i] : -1;
  endfunction

  function automatic int ilog_g(input int i);
    return (gap_log.size() > i) ? gap_log[i] : -1;
  endfunction

  // ---------------- watchdog ----------------
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- directed tests ----------------
  int w0;

  initial begin
    clear_logs();
    rst_n = 1'b0;
    tick(3);
    chk("t0_grant", grant, 0);
    chk("t0_busy", busy, 0);
    chk("t0_wr", tx_wr_en, 0);
    rst_n = 1'b1;
    tick(2);

    // T1: req0 sends "AT\r\n"
    clear_logs();
    push(0, 8'h41, 1); push(0, 8'h54, 1); push(0, CR, 1); push(0, LF, 1);
    wait_drain(40, "t1");
    chk("t1_grant_latency", grant_cyc - valid_cyc, 1);
    chk("t1_grant", glog(0), 3'b001);
    chk("t1_writes", ilog_b(0), 4);
    chk("t1_busy_fall", fall_cyc - last_wr_cyc, 1);

    // T2: all three send "X\r\n" from reset
    do_reset();
    clear_logs();
    for (int r = 0; r < N; r++) begin
      push(r, 8'h58, 1); push(r, CR, 1); push(r, LF, 1);
    end
    wait_drain(60, "t2");
    chk("t2_grant0", glog(0), 3'b001);
    chk("t2_grant1", glog(1), 3'b010);
    chk("t2_grant2", glog(2), 3'b100);
    chk("t2_gap1", ilog_g(1), 1);
    chk("t2_gap2", ilog_g(2), 1);
    chk("t2_len1", ilog_b(1), 3);

    // T3: req1 locked, tx_full for 20 cycles mid-burst
    clear_logs();
    push(1, 8'h41, 1); push(1, 8'h42, 1);
    wait_src_empty(1, 40, "t3");
    full_cfg = 1'b1;
    push(1, CR, 1); push(1, LF, 1);
    tick(1);
    w0 = wr_total;
    tick(10);
    chk("t3_ready_held", req_ready, 0);
    chk("t3_wr_held", tx_wr_en, 0);
    chk("t3_busy_held", busy, 1);
    tick(10);
    chk("t3_no_writes", wr_total - w0, 0);
    full_cfg = 1'b0;
    wait_drain(40, "t3");
    chk("t3_grant", glog(0), 3'b010);
    chk("t3_len", ilog_b(0), 4);
    chk("t3_no_timeout", to_cnt, 0);

    // T4: req2 locked then silent; req0 waits for the timeout release
    clear_logs();
    push(2, 8'h51, 1);
    wait_src_empty(2, 40, "t4");
    push(0, 8'h5A, 1); push(0, CR, 1); push(0, LF, 1);
    wait_drain(1200, "t4");
    chk("t4_to_count", to_cnt, 1);
    chk("t4_to_latency", to_cyc - first_wr_cyc, 1001);
    chk("t4_grant0", glog(0), 3'b100);
    chk("t4_grant1", glog(1), 3'b001);

    // T5: req0 streams 65 x 'A' then CR LF
    clear_logs();
    for (int i = 0; i < 65; i++) push(0, 8'h41, 1);
    push(0, CR, 1); push(0, LF, 1);
    wait_drain(300, "t5");
    chk("t5_ovf_count", ov_cnt, 1);
    chk("t5_ovf_latency", ov_cyc - first_wr_cyc, 64);
    chk("t5_len0", ilog_b(0), 64);
    chk("t5_len1", ilog_b(1), 3);
    chk("t5_gap", ilog_g(1), 1);

    // T6: reset two bytes into a req1 burst
    clear_logs();
    push(1, 8'h48, 1); push(1, 8'h45, 1);
    push(1, 8'h4C, 0); push(1, 8'h4C, 0); push(1, 8'h4F, 0);
    push(1, CR, 0); push(1, LF, 0);
    w0 = wr_total;
    for (int n = 0; n < 40 && (wr_total - w0) < 2; n++) tick(1);
    chk("t6_two_writes", wr_total - w0, 2);
    @(posedge clk);
    #3;
    chk("t6_pre_wr", tx_wr_en, 1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_wr", tx_wr_en, 0);
    chk("t6_rst_data", tx_data, 0);
    chk("t6_rst_grant", grant, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_ready", req_ready, 0);
    src1_q.delete();
    chk("t6_exp_after_rst", exp_q.size(), 0);
    tick(3);
    rst_n = 1'b1;
    tick(1);
    clear_logs();
    push(0, 8'h52, 1); push(0, CR, 1); push(0, LF, 1);
    push(1, 8'h53, 1); push(1, CR, 1); push(1, LF, 1);
    wait_drain(60, "t6");
    chk("t6_grant0", glog(0), 3'b001);
    chk("t6_grant1", glog(1), 3'b010);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
